// File: rtl/multi_port_cam_regfile_pkg.sv
// Shared constants and the mask-compare helper for the multi-port CAM register file.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Holds the default width/depth constants used as parameter defaults by the
// top module, and the masked compare used by every CAM entry comparator.
// Optional feature macro (consumed by the top module): MULTI_PORT_CAM_REGFILE_BYPASS_EN.
package multi_port_cam_regfile_pkg;

    localparam int DEFAULT_ENTRY_WIDTH    = 8;
    localparam int DEFAULT_NUM_ENTRY      = 4;
    localparam int DEFAULT_NUM_READ_PORT  = 2;
    localparam int DEFAULT_NUM_WRITE_PORT = 2;

    // Widest entry the compare helper handles; narrower operands are
    // zero-extended, and the zero-extended mask bits make the extra
    // positions drop out of the compare.
    localparam int CAM_MAX_WIDTH = 64;

    // An entry matches when every bit selected by the mask equals the key.
    function automatic logic masked_match(
        input logic [CAM_MAX_WIDTH-1:0] entry,
        input logic [CAM_MAX_WIDTH-1:0] key,
        input logic [CAM_MAX_WIDTH-1:0] mask
    );
        return ((entry ^ key) & mask) == '0;
    endfunction

endpackage

// File: rtl/multi_port_cam_regfile_priority_encoder_lowest.sv
// Lowest-set-bit priority encoder: index of the lowest set bit plus a found flag.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   vec_in    : multi-hot request vector
//   index_out : lowest set bit position, 0 when vec_in is all zero
//   found_out : OR of vec_in
module priority_encoder_lowest #(
    parameter int NUM_ENTRY      = 4,
    parameter int NUM_ENTRY_LOG2 = $clog2(NUM_ENTRY)
) (
    input  logic [NUM_ENTRY-1:0]      vec_in,
    output logic [NUM_ENTRY_LOG2-1:0] index_out,
    output logic                      found_out
);

    always_comb begin
        index_out = '0;
        found_out = |vec_in;
        // Scan from the top so the lowest set bit is the last assignment.
        for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
            if (vec_in[i]) begin
                index_out = NUM_ENTRY_LOG2'(i);
            end
        end
    end

endmodule

// File: rtl/multi_port_cam_regfile.sv
// Multi-port register file with valid bits and one masked CAM search port.
// Latency: writes/invalidates take effect on the edge; reads and CAM results are registered, 1 cycle.
// Backpressure: none; every port accepts a request every cycle.
//
// Ports:
//   clk_in, reset_in (async, active-high)
//   read_en_in / read_entry_addr_decoded_in / read_entry_out : registered read ports, one-hot select
//   write_en_in / write_entry_addr_decoded_in / write_entry_in : write ports, highest port wins
//   invalidate_en_in / invalidate_entry_decoded_in : clear valid bits (write wins over invalidate)
//   cam_en_in / cam_entry_in / cam_mask_in : masked search over valid entries
//   cam_result_decoded_out / cam_hit_out / cam_hit_index_out : registered CAM results
//   entry_valid_out : current valid bits
// Optional macro MULTI_PORT_CAM_REGFILE_BYPASS_EN: reads and CAM see the post-write
// (and post-invalidate) contents of the same cycle; otherwise they see pre-update state.
module multi_port_cam_regfile
    import multi_port_cam_regfile_pkg::*;
#(
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = DEFAULT_ENTRY_WIDTH,
    parameter int NUM_ENTRY                  = DEFAULT_NUM_ENTRY,
    parameter int NUM_READ_PORT              = DEFAULT_NUM_READ_PORT,
    parameter int NUM_WRITE_PORT             = DEFAULT_NUM_WRITE_PORT,
    parameter int NUM_ENTRY_LOG2             = $clog2(NUM_ENTRY)
) (
    input  logic                                                 clk_in,
    input  logic                                                 reset_in,
    input  logic [NUM_READ_PORT-1:0]                             read_en_in,
    input  logic [NUM_READ_PORT*NUM_ENTRY-1:0]                   read_entry_addr_decoded_in,
    output logic [NUM_READ_PORT*SINGLE_ENTRY_WIDTH_IN_BITS-1:0]  read_entry_out,
    input  logic [NUM_WRITE_PORT-1:0]                            write_en_in,
    input  logic [NUM_WRITE_PORT*NUM_ENTRY-1:0]                  write_entry_addr_decoded_in,
    input  logic [NUM_WRITE_PORT*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] write_entry_in,
    input  logic                                                 invalidate_en_in,
    input  logic [NUM_ENTRY-1:0]                                 invalidate_entry_decoded_in,
    input  logic                                                 cam_en_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]                cam_entry_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]                cam_mask_in,
    output logic [NUM_ENTRY-1:0]                                 cam_result_decoded_out,
    output logic                                                 cam_hit_out,
    output logic [NUM_ENTRY_LOG2-1:0]                            cam_hit_index_out,
    output logic [NUM_ENTRY-1:0]                                 entry_valid_out
);

    localparam int W = SINGLE_ENTRY_WIDTH_IN_BITS;

    logic [W-1:0]         entry_q   [NUM_ENTRY];
    logic [W-1:0]         entry_nxt [NUM_ENTRY];
    logic [NUM_ENTRY-1:0] valid_q;
    logic [NUM_ENTRY-1:0] valid_nxt;

    // Contents seen by the read mux and the CAM comparators.
    logic [W-1:0]         src_entry [NUM_ENTRY];
    logic [NUM_ENTRY-1:0] src_valid;

    logic [W-1:0]         read_q    [NUM_READ_PORT];
    logic [W-1:0]         read_nxt  [NUM_READ_PORT];

    logic [NUM_ENTRY-1:0]      cam_hit_vec;
    logic [NUM_ENTRY_LOG2-1:0] cam_hit_idx;
    logic                      cam_hit_any;

    // Post-update state. Ports are walked in ascending order so the
    // highest-numbered writer is the last assignment and wins; a write
    // also overrides an invalidate of the same entry.
    always_comb begin
        for (int e = 0; e < NUM_ENTRY; e++) begin
            entry_nxt[e] = entry_q[e];
            valid_nxt[e] = valid_q[e] & ~(invalidate_en_in & invalidate_entry_decoded_in[e]);
            for (int w = 0; w < NUM_WRITE_PORT; w++) begin
                if (write_en_in[w] && write_entry_addr_decoded_in[w*NUM_ENTRY + e]) begin
                    entry_nxt[e] = write_entry_in[w*W +: W];
                    valid_nxt[e] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int e = 0; e < NUM_ENTRY; e++) begin
`ifdef MULTI_PORT_CAM_REGFILE_BYPASS_EN
            src_entry[e] = entry_nxt[e];
`else
            src_entry[e] = entry_q[e];
`endif
        end
`ifdef MULTI_PORT_CAM_REGFILE_BYPASS_EN
        src_valid = valid_nxt;
`else
        src_valid = valid_q;
`endif
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int e = 0; e < NUM_ENTRY; e++) begin
                entry_q[e] <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int e = 0; e < NUM_ENTRY; e++) begin
                entry_q[e] <= entry_nxt[e];
            end
            valid_q <= valid_nxt;
        end
    end

    assign entry_valid_out = valid_q;

    // Read mux: OR of every selected entry, so a zero select yields zero.
    // The valid bit is deliberately not consulted.
    always_comb begin
        for (int p = 0; p < NUM_READ_PORT; p++) begin
            read_nxt[p] = '0;
            for (int e = 0; e < NUM_ENTRY; e++) begin
                if (read_entry_addr_decoded_in[p*NUM_ENTRY + e]) begin
                    read_nxt[p] = read_nxt[p] | src_entry[e];
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int p = 0; p < NUM_READ_PORT; p++) begin
                read_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_READ_PORT; p++) begin
                if (read_en_in[p]) begin
                    read_q[p] <= read_nxt[p];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_READ_PORT; p++) begin : g_read_out
        assign read_entry_out[p*W +: W] = read_q[p];
    end

    always_comb begin
        for (int e = 0; e < NUM_ENTRY; e++) begin
            cam_hit_vec[e] = src_valid[e] &
                masked_match(CAM_MAX_WIDTH'(src_entry[e]),
                             CAM_MAX_WIDTH'(cam_entry_in),
                             CAM_MAX_WIDTH'(cam_mask_in));
        end
    end

    priority_encoder_lowest #(
        .NUM_ENTRY      (NUM_ENTRY),
        .NUM_ENTRY_LOG2 (NUM_ENTRY_LOG2)
    ) u_hit_encoder (
        .vec_in    (cam_hit_vec),
        .index_out (cam_hit_idx),
        .found_out (cam_hit_any)
    );

    // A disabled search clears the result rather than holding it.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            cam_result_decoded_out <= '0;
            cam_hit_out            <= 1'b0;
            cam_hit_index_out      <= '0;
        end else if (cam_en_in) begin
            cam_result_decoded_out <= cam_hit_vec;
            cam_hit_out            <= cam_hit_any;
            cam_hit_index_out      <= cam_hit_idx;
        end else begin
            cam_result_decoded_out <= '0;
            cam_hit_out            <= 1'b0;
            cam_hit_index_out      <= '0;
        end
    end

endmodule
